line_fetch_arbiter: RTL and testbench

- Sequences framebuffer reads for the display pipeline and shares the single framebuffer memory port between display fetch and a CPU requester.
- Driven by the display timing generator's `frame`, `line` and `sy` outputs.
- During each active line it prefetches the next line into the idle bank of a double-buffered line buffer, then swaps banks on the next `line` pulse.
- CPU accesses are served only when no display fetch is pending.

---
 rtl/line_fetch_arbiter.sv | 125 ++++++++++++
 tb/tb_line_fetch_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_arbiter.sv
// line_fetch_arbiter: double-buffered display line prefetch sharing one framebuffer port with a CPU (LINE_DOUBLE_EN: show each row twice)
module line_fetch_arbiter #(
  parameter int CORDW = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDRW = 18,
  parameter int DATAW = 32,
  parameter int FB_BASE = 0,
  localparam int WPL = H_RES / PIX_PER_WORD,
  localparam int LBAW = WPL > 1 ? $clog2(WPL) : 1
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRW-1:0]        mem_addr,
  output logic [DATAW-1:0]        mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATAW-1:0]        mem_rdata,
  output logic                    lb_we,
  output logic                    lb_wbank,
  output logic [LBAW-1:0]         lb_waddr,
  output logic [DATAW-1:0]        lb_wdata,
  output logic                    lb_rbank,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDRW-1:0]        cpu_addr,
  input  logic [DATAW-1:0]        cpu_wdata,
  output logic                    cpu_ack,
  output logic [DATAW-1:0]        cpu_rdata,
  output logic                    underrun
);
  typedef enum logic [1:0] {IDLE, DREQ, CREQ} state_t;
  localparam logic signed [CORDW:0] ONE = (CORDW+1)'(1);
  state_t state, state_nx;
  logic fetch_pend, stale, ltrig, trig, do_fetch, d_ack, c_ack, issue_d, issue_c;
  logic [LBAW-1:0] wcnt;
  logic [ADDRW-1:0] line_addr;
  logic signed [CORDW:0] sext, nrow;
  assign sext = {sy[CORDW-1], sy};
`ifdef LINE_DOUBLE_EN
  localparam int ROWS = V_RES / 2;
  assign ltrig = line & ~frame & ~sy[0];
  assign nrow = (sext >>> 1) + ONE;
`else
  localparam int ROWS = V_RES;
  assign ltrig = line & ~frame;
  assign nrow = sext + ONE;
`endif
  assign trig = frame | ltrig;
  assign do_fetch = frame | (ltrig & ~nrow[CORDW] & (nrow < (CORDW+1)'(ROWS)));
  assign d_ack = state == DREQ && mem_ack;
  assign c_ack = state == CREQ && mem_ack;
  assign issue_d = state == IDLE && state_nx == DREQ;
  assign issue_c = state == IDLE && state_nx == CREQ;
  always_ff @(posedge clk_pix)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (trig ? IDLE : fetch_pend ? DREQ : cpu_req ? CREQ : IDLE)
                             : (mem_ack ? IDLE : state);
  end
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      fetch_pend <= 1'b0;
      stale      <= 1'b0;
      wcnt       <= '0;
      line_addr  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lb_we      <= 1'b0;
      lb_wbank   <= 1'b1;
      lb_waddr   <= '0;
      lb_wdata   <= '0;
      lb_rbank   <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      underrun   <= 1'b0;
    end else begin
      lb_we    <= d_ack & ~stale & ~trig;
      cpu_ack  <= c_ack;
      underrun <= trig & fetch_pend;
      stale    <= state == DREQ && !mem_ack && (stale || trig);
      if (d_ack || c_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (issue_d) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= line_addr + ADDRW'(wcnt);
      end
      if (issue_c) begin
        mem_req   <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      if (d_ack) begin
        lb_waddr <= wcnt;
        lb_wdata <= mem_rdata;
      end
      if (c_ack && !mem_we)
        cpu_rdata <= mem_rdata;
      if (d_ack && !stale) begin
        wcnt <= wcnt + LBAW'(1);
        if (wcnt == LBAW'(WPL - 1))
          fetch_pend <= 1'b0;
      end
      if (trig) begin
        fetch_pend <= do_fetch;
        wcnt       <= '0;
        line_addr  <= frame ? ADDRW'(FB_BASE) : ADDRW'(nrow) * ADDRW'(WPL) + ADDRW'(FB_BASE);
        lb_wbank   <= frame ? ~lb_rbank : lb_rbank;
        lb_rbank   <= lb_rbank ^ ~frame;
      end
    end
  end
endmodule

// File: tb/tb_line_fetch_arbiter.sv
// tb_line_fetch_arbiter: randomized scoreboard bench for line_fetch_arbiter
module tb_line_fetch_arbiter;
  localparam int V_RES = 8;
  localparam int WPL = 4;
  localparam int FB_BASE = 0;
  typedef struct packed {logic bank; logic [1:0] idx; logic [31:0] data;} lbw_t;
  logic clk_pix = 1'b0;
  logic rst, frame, line, mem_req, mem_we, mem_ack, lb_we, lb_wbank, lb_rbank;
  logic cpu_req, cpu_we, cpu_ack, underrun, mem_init;
  logic signed [15:0] sy;
  logic [17:0] mem_addr, cpu_addr;
  logic [31:0] mem_wdata, mem_rdata, lb_wdata, cpu_wdata, cpu_rdata;
  logic [1:0] lb_waddr;
  logic [3:0] lat, wc;
  logic [31:0] smem [0:511];
  logic [511:0] swr;
  logic [31:0] mmem [0:511];
  lbw_t lbq [$];
  logic [31:0] cpuq [$];
  logic exp_rbank = 1'b0;
  logic [31:0] exp_cpu_rdata = '0;
  int tests = 0, fails = 0, wr_cnt = 0, und_cnt = 0, exp_und = 0, req_cycles = 0;
  bit lines_busy;
  always #5 clk_pix = ~clk_pix;
  line_fetch_arbiter #(.CORDW(16), .H_RES(16), .V_RES(V_RES), .PIX_PER_WORD(4),
                       .ADDRW(18), .DATAW(32), .FB_BASE(FB_BASE)) dut (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .line(line), .sy(sy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_wbank(lb_wbank),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_rbank(lb_rbank), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .underrun(underrun));
  function automatic logic [31:0] dflt(input logic [17:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign mem_ack = mem_req && wc == lat;
  assign mem_rdata = swr[mem_addr[8:0]] ? smem[mem_addr[8:0]] : dflt(mem_addr);
  always @(posedge clk_pix) begin
    wc <= (!mem_req || mem_ack) ? 4'd0 : wc + 4'd1;
    if (mem_init)
      swr <= '0;
    else if (mem_req && mem_ack && mem_we) begin
      swr[mem_addr[8:0]] <= 1'b1;
      smem[mem_addr[8:0]] <= mem_wdata;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk_pix);
    if (lb_we) begin
      wr_cnt++;
      chk("lb_pending", lbq.size() != 0, 1);
      if (lbq.size() != 0) chk("lb_write", {lb_wbank, lb_waddr, lb_wdata}, lbq.pop_front());
    end
    if (cpu_ack) begin
      chk("cpu_pending", cpuq.size() != 0, 1);
      if (cpuq.size() != 0) chk("cpu_rdata", cpu_rdata, cpuq.pop_front());
    end
    if (underrun) und_cnt++;
    if (mem_req) req_cycles++;
  end
  task automatic pulse(input logic f, input logic l, input int s);
    logic b;
    int row;
    bit fe;
    @(negedge clk_pix); #1;
    frame = f; line = l; sy = 16'(s);
    if (lbq.size() != 0) exp_und++;
    lbq.delete();
    fe = 0; b = 0; row = 0;
    if (f) begin
      b = !exp_rbank; fe = 1;
    end else begin
      b = exp_rbank; exp_rbank = !exp_rbank; row = s + 1; fe = row < V_RES;
    end
    if (fe)
      for (int i = 0; i < WPL; i++)
        lbq.push_back({b, 2'(i), mmem[9'(row * WPL + FB_BASE + i)]});
    @(negedge clk_pix); #1;
    frame = 0; line = 0;
    chk("lb_rbank", lb_rbank, exp_rbank);
  endtask
  task automatic cpu_xact(input logic we, input logic [17:0] a, input logic [31:0] d);
    bit got;
    @(negedge clk_pix); #1;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) mmem[a[8:0]] = d;
    else exp_cpu_rdata = mmem[a[8:0]];
    cpuq.push_back(exp_cpu_rdata);
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk_pix);
      got = cpu_ack;
    end
    chk("cpu_ack_seen", got, 1);
    #1 cpu_req = 0;
  endtask
  task automatic drain();
    for (int k = 0; k < 300 && lbq.size() != 0; k++) @(negedge clk_pix);
    chk("drain", lbq.size(), 0);
    repeat (8) @(negedge clk_pix);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w0, u0, rc;
    rst = 1; mem_init = 1; frame = 0; line = 0; sy = 0; lat = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < 512; i++) mmem[i] = dflt(18'(i));
    repeat (3) @(negedge clk_pix);
    chk("rst_ctl", {mem_req, mem_we, lb_we, cpu_ack, underrun, lb_rbank, lb_wbank}, 7'b0000001);
    chk("rst_addr", {mem_addr, lb_waddr}, 0);
    chk("rst_wdata", {mem_wdata, lb_wdata}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    #1 rst = 0; mem_init = 0;
    pulse(1, 0, 0);
    drain();
    chk("frame_no_underrun", und_cnt, 0);
    pulse(0, 1, 5);
    drain();
    rc = req_cycles;
    pulse(0, 1, V_RES - 1);
    repeat (20) @(negedge clk_pix);
    chk("last_line_no_req", req_cycles - rc, 0);
    lat = 1;
    fork
      cpu_xact(1, 18'h100, 32'hDEAD_BEEF);
      begin
        int ka;
        bit seen, done;
        ka = -100; seen = 0; done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
          @(negedge clk_pix);
          if (mem_req && !seen) begin
            seen = 1;
            chk("cpu_w_issue", {mem_we, mem_addr}, {1'b1, 18'h100});
          end
          if (mem_req && mem_ack) ka = k;
          if (cpu_ack) begin
            done = 1;
            chk("cpu_w_ack_lat", k - ka, 1);
          end
        end
        chk("cpu_w_done", done, 1);
      end
    join
    lat = 3;
    w0 = wr_cnt;
    pulse(0, 1, 2);
    cpu_xact(0, 18'h100, 0);
    chk("cpu_after_fetch", wr_cnt - w0, 4);
    drain();
    u0 = und_cnt; w0 = wr_cnt;
    pulse(0, 1, 0);
    for (int k = 0; k < 100 && wr_cnt - w0 < 2; k++) begin @(negedge clk_pix); #1; end
    for (int k = 0; k < 100 && !mem_req; k++) begin @(negedge clk_pix); #1; end
    chk("underrun_setup", wr_cnt - w0, 2);
    pulse(0, 1, 1);
    drain();
    chk("underrun_once", und_cnt - u0, 1);
    for (int sg = 0; sg < 4; sg++) begin
      lat = 4'($urandom_range(0, 3));
      lines_busy = 1;
      fork
        begin
          for (int e = 0; e < 12; e++) begin
            int r;
            r = $urandom_range(0, 9);
            pulse(r < 2, r != 0, $urandom_range(0, V_RES - 1));
            repeat ($urandom_range(30, 50)) @(negedge clk_pix);
          end
          lines_busy = 0;
        end
        while (lines_busy) begin
          repeat ($urandom_range(0, 10)) @(negedge clk_pix);
          cpu_xact(1'($urandom_range(0, 1)), 18'h100 + 18'($urandom_range(0, 15)), $urandom);
        end
      join
      drain();
    end
    lat = 3;
    pulse(1, 0, 0);
    repeat (2) @(negedge clk_pix);
    #1 rst = 1;
    lbq.delete(); exp_rbank = 0; exp_cpu_rdata = 0;
    @(negedge clk_pix);
    chk("rst_mid", {mem_req, lb_we, lb_rbank, lb_wbank}, 4'b0001);
    #1 rst = 0;
    rc = req_cycles;
    repeat (30) @(negedge clk_pix);
    chk("rst_mid_idle", req_cycles - rc, 0);
    chk("underrun_total", und_cnt, exp_und);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
